multicycle_control: RTL and testbench

Multi-cycle sequencer that drives the existing single-cycle datapath (register file, ALU, immediate generator, data memory) over several clock cycles per instruction. It replaces the combinational control unit at the top level. It decodes an RV32I subset from the instruction register, steps a fetch/decode/execute/memory/writeback state machine, and handshakes with a variable-latency data memory. It also provides a trap state and a retired-instruction counter.

---
 rtl/multicycle_control_if.sv | 33 +++
 rtl/multicycle_control.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer and the single-cycle datapath.
// The master side is the sequencer. The slave side is the datapath and memory.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      inst;
    logic [3:0]       status;
    logic             mem_ready;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCSrc;
    logic             RegWrite;
    logic             ALUSrc;
    logic [3:0]       ALU_operation;
    logic [1:0]       immselect;
    logic             mem_req;
    logic             write;
    logic             MemtoReg;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  inst, status, mem_ready,
        output IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, ALU_operation,
               immselect, mem_req, write, MemtoReg, halted, retired
    );

    modport slave (
        output inst, status, mem_ready,
        input  IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, ALU_operation,
               immselect, mem_req, write, MemtoReg, halted, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle sequencer for an RV32I subset. It walks
// FETCH/DECODE/EXEC/MEM/WB around the single-cycle datapath, waits on a
// variable-latency data memory with a timeout, traps on an illegal
// instruction and counts retired instructions.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] C_R  = 3'd0;
    localparam logic [2:0] C_I  = 3'd1;
    localparam logic [2:0] C_LD = 3'd2;
    localparam logic [2:0] C_ST = 3'd3;
    localparam logic [2:0] C_BR = 3'd4;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       cls_q;
    logic [3:0]       alu_op_q;
    logic [1:0]       br_q;
    logic [7:0]       tmo_q;
    logic [CNT_W-1:0] retired_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       dec_legal;
    logic [2:0] dec_cls;
    logic [3:0] dec_op;
    logic [1:0] dec_br;
    logic [3:0] f3_op;
    logic       f3_ok;
    logic       taken;
    logic       pc_write;
    logic       unused_bits;

    assign opcode      = bus.inst[6:0];
    assign funct3      = bus.inst[14:12];
    assign funct7_5    = bus.inst[30];
    assign unused_bits = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:7], bus.status[2]};

    // Shared funct3 -> ALU operation map for R-type and I-ALU (000 resolved by caller)
    always_comb begin
        f3_ok = 1'b1;
        f3_op = OP_ADD;
        case (funct3)
            3'b000:  f3_op = OP_ADD;
            3'b111:  f3_op = OP_AND;
            3'b110:  f3_op = OP_OR;
            3'b100:  f3_op = OP_XOR;
            3'b010:  f3_op = OP_SLT;
            default: f3_ok = 1'b0;
        endcase
    end

    // Instruction decode: class, ALU operation, branch kind and legality
    always_comb begin
        dec_legal = 1'b0;
        dec_cls   = C_R;
        dec_op    = OP_ADD;
        dec_br    = 2'b00;
        case (opcode)
            7'b0110011: begin
                dec_cls   = C_R;
                dec_legal = f3_ok;
                dec_op    = (funct3 == 3'b000 && funct7_5) ? OP_SUB : f3_op;
            end
            7'b0010011: begin
                dec_cls   = C_I;
                dec_legal = f3_ok;
                dec_op    = f3_op;
            end
            7'b0000011: begin
                dec_cls   = C_LD;
                dec_legal = (funct3 == 3'b010);
            end
            7'b0100011: begin
                dec_cls   = C_ST;
                dec_legal = (funct3 == 3'b010);
            end
            7'b1100011: begin
                dec_cls = C_BR;
                dec_op  = OP_SUB;
                case (funct3)
                    3'b000:  begin dec_br = 2'b00; dec_legal = 1'b1; end
                    3'b001:  begin dec_br = 2'b01; dec_legal = 1'b1; end
                    3'b100:  begin dec_br = 2'b10; dec_legal = 1'b1; end
                    3'b101:  begin dec_br = 2'b11; dec_legal = 1'b1; end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Branch condition from the live ALU flags
    always_comb begin
        case (br_q)
            2'b00:   taken = bus.status[0];
            2'b01:   taken = !bus.status[0];
            2'b10:   taken = bus.status[1] ^ bus.status[3];
            default: taken = !(bus.status[1] ^ bus.status[3]);
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (cls_q)
                    C_R, C_I:   state_d = S_WB;
                    C_LD, C_ST: state_d = S_MEM;
                    default:    state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready)
                    state_d = (cls_q == C_ST) ? S_FETCH : S_WB;
                else if (tmo_q == TMO_LAST)
                    state_d = S_TRAP;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Moore control outputs; PCSrc and the MEM-exit PCWrite follow live inputs
    always_comb begin
        bus.IRWrite       = 1'b0;
        pc_write          = 1'b0;
        bus.PCSrc         = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ALUSrc        = 1'b0;
        bus.ALU_operation = '0;
        bus.immselect     = 2'b00;
        bus.mem_req       = 1'b0;
        bus.write         = 1'b0;
        bus.MemtoReg      = 1'b0;
        // ALU operand selection stays stable through MEM and WB so the
        // datapath result remains valid until it is written back.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            bus.ALU_operation = alu_op_q;
            bus.ALUSrc        = (cls_q == C_I || cls_q == C_LD || cls_q == C_ST);
            bus.immselect     = (cls_q == C_ST) ? 2'b01 : (cls_q == C_BR) ? 2'b10 : 2'b00;
        end
        case (state_q)
            S_FETCH: bus.IRWrite = 1'b1;
            S_EXEC: begin
                if (cls_q == C_BR) begin
                    pc_write  = 1'b1;
                    bus.PCSrc = taken;
                end
            end
            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.write   = (cls_q == C_ST);
                pc_write    = (cls_q == C_ST) && bus.mem_ready;
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = (cls_q == C_LD);
                pc_write     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite = pc_write;
    assign bus.halted  = (state_q == S_TRAP);
    assign bus.retired = retired_q;

    // State register plus decoded-instruction registers captured in DECODE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            cls_q    <= C_R;
            alu_op_q <= '0;
            br_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q    <= dec_cls;
                alu_op_q <= dec_op;
                br_q     <= dec_br;
            end
        end
    end

    // Memory timeout counter: zero outside MEM, counts MEM cycles without ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_q <= '0;
        else if (state_q != S_MEM)
            tmo_q <= '0;
        else if (!bus.mem_ready)
            tmo_q <= tmo_q + 8'd1;
    end

    // Retired-instruction counter, one increment per PCWrite pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retired_q <= '0;
        else if (pc_write)
            retired_q <= retired_q + CNT_W'(1);
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control with hand-computed control words.
module tb_multicycle_control;
    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    // Control word layout: [14]IRWrite [13]PCWrite [12]PCSrc [11]RegWrite
    // [10]ALUSrc [9:6]ALU_operation [5:4]immselect [3]mem_req [2]write
    // [1]MemtoReg [0]halted
    localparam logic [31:0] M_ALL   = 32'h7FFF;
    localparam logic [31:0] M_WB    = 32'h780F;
    localparam logic [31:0] M_NOIMM = 32'h7FCF;

    multicycle_control_if #(.CNT_W(32)) bus ();

    multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ev(input logic irw, input logic pcw, input logic pcs,
                                       input logic rw, input logic alus, input logic [3:0] op,
                                       input logic [1:0] imm, input logic mreq, input logic wr,
                                       input logic m2r, input logic halt);
        return {17'd0, irw, pcw, pcs, rw, alus, op, imm, mreq, wr, m2r, halt};
    endfunction

    function automatic logic [31:0] ctl();
        return {17'd0, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.RegWrite, bus.ALUSrc,
                bus.ALU_operation, bus.immselect, bus.mem_req, bus.write, bus.MemtoReg,
                bus.halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [31:0] exp, input logic [31:0] mask);
        chk(tag, ctl() & mask, exp & mask);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Checks FETCH and DECODE, leaving the bench in the cycle after DECODE
    task automatic fetch_decode(input string tag);
        chk_ctl({tag, "_fetch"}, ev(1,0,0,0,0,4'b0000,2'b00,0,0,0,0), M_ALL);
        tick();
        chk_ctl({tag, "_decode"}, 32'h0, M_ALL);
        tick();
    endtask

    logic [31:0] E_FETCH, E_TRAP;
    logic [31:0] E_LD_MEM;

    initial begin
        nvec = 0;
        nerr = 0;
        E_FETCH  = ev(1,0,0,0,0,4'b0000,2'b00,0,0,0,0);
        E_TRAP   = ev(0,0,0,0,0,4'b0000,2'b00,0,0,0,1);
        E_LD_MEM = ev(0,0,0,0,1,4'b0010,2'b00,1,0,0,0);

        reset         = 1'b0;
        bus.inst      = 32'h0;
        bus.status    = 4'b0000;
        bus.mem_ready = 1'b0;
        #1;
        chk_ctl("reset_ctl", E_FETCH, M_ALL);
        chk("reset_retired", bus.retired, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk_ctl("reset_held", E_FETCH, M_ALL);
        reset = 1'b1;

        // add x3,x1,x2
        bus.inst = 32'h002081B3;
        fetch_decode("add");
        chk_ctl("add_exec", ev(0,0,0,0,0,4'b0010,2'b00,0,0,0,0), M_NOIMM);
        tick();
        chk_ctl("add_wb", ev(0,1,0,1,0,4'b0000,2'b00,0,0,0,0), M_WB);
        chk("add_retired_wb", bus.retired, 32'd0);
        tick();
        chk("add_retired", bus.retired, 32'd1);

        // beq x0,x0,8 taken, with a live status flip showing PCSrc tracks Z
        bus.inst   = 32'h00000463;
        bus.status = 4'b0001;
        fetch_decode("beq_t");
        chk_ctl("beq_t_exec", ev(0,1,1,0,0,4'b0110,2'b10,0,0,0,0), M_ALL);
        bus.status = 4'b0000;
        #1;
        chk_ctl("beq_live_z", ev(0,1,0,0,0,4'b0110,2'b10,0,0,0,0), M_ALL);
        bus.status = 4'b0001;
        tick();
        chk_ctl("beq_t_next", E_FETCH, M_ALL);
        chk("beq_t_retired", bus.retired, 32'd2);

        // beq not taken
        bus.status = 4'b0000;
        fetch_decode("beq_n");
        chk_ctl("beq_n_exec", ev(0,1,0,0,0,4'b0110,2'b10,0,0,0,0), M_ALL);
        tick();
        chk("beq_n_retired", bus.retired, 32'd3);

        // blt taken on N=1,V=0
        bus.inst   = 32'h00004463;
        bus.status = 4'b0010;
        fetch_decode("blt");
        chk_ctl("blt_exec", ev(0,1,1,0,0,4'b0110,2'b10,0,0,0,0), M_ALL);
        tick();
        chk("blt_retired", bus.retired, 32'd4);
        bus.status = 4'b0000;

        // xori x1,x1,5
        bus.inst = 32'h0050C093;
        fetch_decode("xori");
        chk_ctl("xori_exec", ev(0,0,0,0,1,4'b0011,2'b00,0,0,0,0), M_ALL);
        tick();
        chk_ctl("xori_wb", ev(0,1,0,1,0,4'b0000,2'b00,0,0,0,0), M_WB);
        tick();
        chk("xori_retired", bus.retired, 32'd5);

        // sub x3,x1,x2
        bus.inst = 32'h402081B3;
        fetch_decode("sub");
        chk_ctl("sub_exec", ev(0,0,0,0,0,4'b0110,2'b00,0,0,0,0), M_NOIMM);
        tick();
        tick();
        chk("sub_retired", bus.retired, 32'd6);

        // lw x5,0(x1), mem_ready on the 4th MEM cycle
        bus.inst = 32'h0000A283;
        fetch_decode("lw");
        chk_ctl("lw_exec", ev(0,0,0,0,1,4'b0010,2'b00,0,0,0,0), M_ALL);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_ctl("lw_mem_wait", E_LD_MEM, M_ALL);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk_ctl("lw_mem_ready", E_LD_MEM, M_ALL);
        tick();
        bus.mem_ready = 1'b0;
        chk_ctl("lw_wb", ev(0,1,0,1,0,4'b0000,2'b00,0,0,1,0), M_WB);
        tick();
        chk_ctl("lw_next", E_FETCH, M_ALL);
        chk("lw_retired", bus.retired, 32'd7);

        // sw x5,4(x1), memory ready immediately
        bus.inst      = 32'h0050A223;
        bus.mem_ready = 1'b1;
        fetch_decode("sw");
        chk_ctl("sw_exec", ev(0,0,0,0,1,4'b0010,2'b01,0,0,0,0), M_ALL);
        tick();
        chk_ctl("sw_mem", ev(0,1,0,0,1,4'b0010,2'b01,1,1,0,0), M_ALL);
        tick();
        bus.mem_ready = 1'b0;
        chk_ctl("sw_next", E_FETCH, M_ALL);
        chk("sw_retired", bus.retired, 32'd8);

        // lw whose mem_ready arrives on the last MEM cycle before timeout
        bus.inst = 32'h0000A283;
        fetch_decode("lw_edge");
        tick();
        for (int i = 0; i < 15; i++) begin
            chk_ctl("lw_edge_wait", E_LD_MEM, M_ALL);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk_ctl("lw_edge_ready", E_LD_MEM, M_ALL);
        tick();
        bus.mem_ready = 1'b0;
        chk_ctl("lw_edge_wb", ev(0,1,0,1,0,4'b0000,2'b00,0,0,1,0), M_WB);
        tick();
        chk("lw_edge_retired", bus.retired, 32'd9);

        // lw with mem_ready stuck low: TRAP after exactly 16 MEM cycles
        fetch_decode("lw_tmo");
        tick();
        for (int i = 0; i < 16; i++) begin
            chk_ctl("lw_tmo_wait", E_LD_MEM, M_ALL);
            tick();
        end
        chk_ctl("lw_tmo_trap", E_TRAP, M_ALL);
        chk("lw_tmo_retired", bus.retired, 32'd9);
        tick();
        chk_ctl("lw_tmo_sticky", E_TRAP, M_ALL);

        // reset asserted mid-TRAP acts immediately
        reset = 1'b0;
        #1;
        chk_ctl("trap_reset_ctl", E_FETCH, M_ALL);
        chk("trap_reset_retired", bus.retired, 32'd0);
        tick();
        reset = 1'b1;

        // add to move retired off zero, then the illegal 0xFFFFFFFF
        bus.inst = 32'h002081B3;
        fetch_decode("add2");
        tick();
        tick();
        chk("add2_retired", bus.retired, 32'd1);
        bus.inst = 32'hFFFFFFFF;
        fetch_decode("ill");
        chk_ctl("ill_trap", E_TRAP, M_ALL);
        bus.mem_ready = 1'b1;
        bus.status    = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_ctl("ill_sticky", E_TRAP, M_ALL);
        end
        chk("ill_retired", bus.retired, 32'd1);
        bus.mem_ready = 1'b0;
        bus.status    = 4'b0000;

        reset = 1'b0;
        #1;
        chk_ctl("ill_reset", E_FETCH, M_ALL);
        tick();
        reset = 1'b1;

        // slli is a shift and therefore illegal
        bus.inst = 32'h00209093;
        fetch_decode("slli");
        chk_ctl("slli_trap", E_TRAP, M_ALL);
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;

        // reset during WB aborts without a RegWrite/PCWrite pulse
        bus.inst = 32'h002081B3;
        fetch_decode("abort");
        tick();
        chk_ctl("abort_wb", ev(0,1,0,1,0,4'b0000,2'b00,0,0,0,0), M_WB);
        reset = 1'b0;
        #1;
        chk_ctl("abort_ctl", E_FETCH, M_ALL);
        @(posedge clk);
        #2;
        chk("abort_retired", bus.retired, 32'd0);
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
